vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1024, visible pixels per line.
REQ-002 SHALL have parameter H_SYNC_START, default 1048, first hcount with hsync asserted.
REQ-003 SHALL have parameter H_SYNC_END, default 1184, first hcount after hsync deasserts.
REQ-004 SHALL have parameter H_TOTAL, default 1344, pixels per line including blanking.
REQ-005 SHALL have parameter V_ACTIVE, default 768, visible lines per frame.
REQ-006 SHALL have parameter V_SYNC_START, default 771, first vcount with vsync asserted.
REQ-007 SHALL have parameter V_SYNC_END, default 777, first vcount after vsync deasserts.
REQ-008 SHALL have parameter V_TOTAL, default 806, lines per frame including blanking.
REQ-009 SHALL have port clk  input  1  pixel clock; all logic on its rising edge.
REQ-010 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-011 SHALL have port bus_out  output  vga_bus  hcount/vcount 11 bits each, hsync/hblnk/vsync/vblnk 1 bit each, rgb 12 bits.
REQ-012 SHALL have port sof  output  1  one-cycle pulse coincident with hcount=0, vcount=0.

Function
REQ-013 SHALL keep an internal 11-bit horizontal counter incrementing by 1 each clk.
REQ-014 SHALL wrap the horizontal counter from H_TOTAL-1 to 0 and, in that same cycle, increment the vertical counter.
REQ-015 SHALL wrap the vertical counter from V_TOTAL-1 to 0 when the horizontal counter also wraps; the frame restarts at (0,0) with no idle cycle.
REQ-016 SHALL drive all bus_out fields from registers, so that hcount, vcount and all four flags describe the same pixel in the same cycle.
REQ-017 SHALL assert hblnk when hcount >= H_ACTIVE, and deassert it otherwise.
REQ-018 SHALL assert hsync when H_SYNC_START <= hcount < H_SYNC_END (active-high).
REQ-019 SHALL assert vblnk when vcount >= V_ACTIVE for every pixel of the line, including hcount 0.
REQ-020 SHALL assert vsync when V_SYNC_START <= vcount < V_SYNC_END for the whole line (active-high).
REQ-021 SHALL drive bus_out.rgb to 12'h000 at all times; downstream draw stages overwrite it.
REQ-022 SHALL assert sof for exactly one cycle per frame, namely the cycle in which bus_out shows hcount=0 and vcount=0.
REQ-023 SHALL hold the counters below H_TOTAL and V_TOTAL at all times; no value outside range shall ever appear on bus_out.

Reset
REQ-024 SHALL, while rst=0 at a clk edge, set hcount=0, vcount=0, hsync=0, hblnk=0, vsync=0, vblnk=0, rgb=0 and sof=0.
REQ-025 SHALL, on the first clk edge with rst=1, present hcount=0, vcount=0 and assert sof.
REQ-026 SHALL abandon the current frame without completing the line when reset is asserted mid-frame, and restart at (0,0) on release.

Configuration
REQ-027 SHALL, when macro VGA_TIMING_FRAME_CNT_EN is defined, add output frame_cnt (16 bits) that resets to 0 and increments in the same cycle as each sof after the first one following reset.
REQ-028 SHALL let frame_cnt wrap from 16'hFFFF to 0.
REQ-029 SHALL, without VGA_TIMING_FRAME_CNT_EN, omit the frame_cnt port and its counter entirely, with all other behaviour identical.

Verification
REQ-030 SHALL cover reset release: rst low for 5 cycles, then high -> first cycle shows hcount=0, vcount=0, sof=1, all flags 0.
REQ-031 SHALL cover horizontal timing: observe one line -> hblnk=1 exactly for hcount 1024..1343, hsync=1 exactly for 1048..1183, and hcount goes 1343->0 while vcount goes 0->1.
REQ-032 SHALL cover vertical timing: run one full frame (1344*806 cycles) -> vblnk=1 for vcount 768..805, vsync=1 for 771..776, and (1343,805) is followed by (0,0) with sof=1.
REQ-033 SHALL cover mid-frame reset: assert rst=0 at hcount=500, vcount=300 for 1 cycle -> next active output is (0,0) with sof=1.
REQ-034 SHALL cover the frame counter with VGA_TIMING_FRAME_CNT_EN defined: run 3 frames -> frame_cnt reads 0, 1, 2 at successive sof pulses.
REQ-035 SHALL cover sof count: over 10 frames, exactly 10 sof pulses occur, each exactly 1344*806 cycles apart.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA timing generator: free-running pixel/line counters with registered
// sync, blanking and start-of-frame outputs on a single vga_bus.
// Optional macro VGA_TIMING_FRAME_CNT_EN adds a 16-bit frame counter output.

package vga_pkg;
    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        hblnk;
        logic        vsync;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_bus;
endpackage

module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE     = 1024,
    parameter int H_SYNC_START = 1048,
    parameter int H_SYNC_END   = 1184,
    parameter int H_TOTAL      = 1344,
    parameter int V_ACTIVE     = 768,
    parameter int V_SYNC_START = 771,
    parameter int V_SYNC_END   = 777,
    parameter int V_TOTAL      = 806
) (
    input  logic   clk,
    input  logic   rst,
    output vga_bus bus_out,
    output logic   sof
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam logic [10:0] HA  = 11'(H_ACTIVE);
    localparam logic [10:0] HSS = 11'(H_SYNC_START);
    localparam logic [10:0] HSE = 11'(H_SYNC_END);
    localparam logic [10:0] HL  = 11'(H_TOTAL - 1);
    localparam logic [10:0] VA  = 11'(V_ACTIVE);
    localparam logic [10:0] VSS = 11'(V_SYNC_START);
    localparam logic [10:0] VSE = 11'(V_SYNC_END);
    localparam logic [10:0] VL  = 11'(V_TOTAL - 1);

    // h_ptr/v_ptr name the pixel that bus_out will show after the next edge,
    // so the first edge out of reset presents (0,0) with sof already set.
    logic [10:0] h_ptr, v_ptr;
    logic        h_last, v_last, at_origin;

    assign h_last    = (h_ptr == HL);
    assign v_last    = (v_ptr == VL);
    assign at_origin = (h_ptr == 11'd0) && (v_ptr == 11'd0);

    // Pixel/line counters; line advances in the same cycle the pixel wraps.
    always_ff @(posedge clk) begin
        if (!rst) begin
            h_ptr <= 11'd0;
            v_ptr <= 11'd0;
        end else if (h_last) begin
            h_ptr <= 11'd0;
            v_ptr <= v_last ? 11'd0 : v_ptr + 11'd1;
        end else begin
            h_ptr <= h_ptr + 11'd1;
        end
    end

    // Register every bus field from the same counter values so they stay aligned.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus_out <= '0;
            sof     <= 1'b0;
        end else begin
            bus_out.hcount <= h_ptr;
            bus_out.vcount <= v_ptr;
            bus_out.hblnk  <= (h_ptr >= HA);
            bus_out.hsync  <= (h_ptr >= HSS) && (h_ptr < HSE);
            bus_out.vblnk  <= (v_ptr >= VA);
            bus_out.vsync  <= (v_ptr >= VSS) && (v_ptr < VSE);
            bus_out.rgb    <= 12'h000;
            sof            <= at_origin;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic sof_seen;

    // Count frames; the first sof after reset leaves the count at 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_cnt <= 16'd0;
            sof_seen  <= 1'b0;
        end else if (at_origin) begin
            sof_seen <= 1'b1;
            if (sof_seen) frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen using a shrunken raster so that full
// frames fit in a short run. Optional frame counter checked when
// VGA_TIMING_FRAME_CNT_EN is defined.

module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int HA = 16, HSS = 18, HSE = 22, HT = 26;
    localparam int VA = 6,  VSS = 7,  VSE = 9,  VT = 11;
    localparam int FRAME = HT * VT;  // 286 cycles

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    vga_bus bus;
    logic   sof;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int passed = 0;
    int total  = 0;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus_out(bus),
        .sof(sof)
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        .frame_cnt(frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {bus, sof} for pixel (h,v), built from the raster constants.
    function automatic logic [38:0] exp_pix(input int h, input int v);
        logic hs, hb, vs, vb, s;
        hb = (h >= HA);
        hs = (h >= HSS) && (h < HSE);
        vb = (v >= VA);
        vs = (v >= VSS) && (v < VSE);
        s  = (h == 0) && (v == 0);
        return {11'(h), 11'(v), hs, hb, vs, vb, 12'h000, s};
    endfunction

    initial begin
        int eh, ev;
        int hb_min, hb_max, hs_min, hs_max, vb_min, vb_max, vs_min, vs_max;
        int wrap_h;
        int nsof, last;
        bit found;

        // Reset held for 5 cycles: everything zero.
        rst = 1'b0;
        repeat (5) tick();
        chk("reset_bus", 64'(bus), 64'd0);
        chk("reset_sof", 64'(sof), 64'd0);

        // Release: first cycle shows origin with sof.
        rst = 1'b1;
        tick();
        chk("release_pix", 64'({bus, sof}), 64'(exp_pix(0, 0)));
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("fcnt_first", 64'(frame_cnt), 64'd0);
`endif

        // One full frame, checked pixel by pixel, with flag extents recorded.
        eh = 0; ev = 0;
        hb_min = 999; hb_max = -1; hs_min = 999; hs_max = -1;
        vb_min = 999; vb_max = -1; vs_min = 999; vs_max = -1;
        wrap_h = -1;
        for (int c = 0; c < FRAME; c++) begin
            chk("pixel", 64'({bus, sof}), 64'(exp_pix(eh, ev)));
            if (ev == 0 && bus.hblnk) begin
                if (eh < hb_min) hb_min = eh;
                if (eh > hb_max) hb_max = eh;
            end
            if (ev == 0 && bus.hsync) begin
                if (eh < hs_min) hs_min = eh;
                if (eh > hs_max) hs_max = eh;
            end
            if (eh == 0 && bus.vblnk) begin
                if (ev < vb_min) vb_min = ev;
                if (ev > vb_max) vb_max = ev;
            end
            if (eh == 0 && bus.vsync) begin
                if (ev < vs_min) vs_min = ev;
                if (ev > vs_max) vs_max = ev;
            end
            if (ev == 0) wrap_h = int'(bus.hcount);
            if (eh == HT - 1) begin
                eh = 0;
                ev = (ev == VT - 1) ? 0 : ev + 1;
            end else begin
                eh++;
            end
            tick();
        end
        chk("hblnk_first", 64'(hb_min), 64'd16);
        chk("hblnk_last",  64'(hb_max), 64'd25);
        chk("hsync_first", 64'(hs_min), 64'd18);
        chk("hsync_last",  64'(hs_max), 64'd21);
        chk("vblnk_first", 64'(vb_min), 64'd6);
        chk("vblnk_last",  64'(vb_max), 64'd10);
        chk("vsync_first", 64'(vs_min), 64'd7);
        chk("vsync_last",  64'(vs_max), 64'd8);
        chk("line_wrap_h", 64'(wrap_h), 64'd25);
        chk("frame_wrap",  64'({bus, sof}), 64'(exp_pix(0, 0)));
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("fcnt_second", 64'(frame_cnt), 64'd1);
`endif

        // Ten more frames: ten sof pulses, each one frame apart.
        nsof = 0; last = 0;
        for (int c = 1; c <= 10 * FRAME; c++) begin
            tick();
            if (sof) begin
                nsof++;
                chk("sof_gap", 64'(c - last), 64'(FRAME));
                last = c;
            end
        end
        chk("sof_count", 64'(nsof), 64'd10);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("fcnt_after10", 64'(frame_cnt), 64'd11);
`endif

        // Mid-frame reset at (10,4) for one cycle.
        found = 1'b0;
        for (int c = 0; c < 2 * FRAME && !found; c++) begin
            if (bus.hcount == 11'd10 && bus.vcount == 11'd4) found = 1'b1;
            else tick();
        end
        chk("mid_found", 64'(found), 64'd1);
        rst = 1'b0;
        tick();
        chk("mid_reset_bus", 64'({bus, sof}), 64'd0);
        rst = 1'b1;
        tick();
        chk("mid_release_pix", 64'({bus, sof}), 64'(exp_pix(0, 0)));
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("fcnt_mid0", 64'(frame_cnt), 64'd0);
`endif
        repeat (FRAME) tick();
        chk("mid_next_sof", 64'({bus, sof}), 64'(exp_pix(0, 0)));
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("fcnt_mid1", 64'(frame_cnt), 64'd1);
`endif
        repeat (FRAME) tick();
        chk("mid_third_sof", 64'(sof), 64'd1);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("fcnt_mid2", 64'(frame_cnt), 64'd2);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
